// File: rtl/layer_tile_scheduler.sv
// ---------------------------------------------------------------------------
// layer_tile_scheduler
//
// Sequences one conv/GEMM layer as a nested (m, n, k) loop of tile passes on
// the systolic core. One core_start pulse is issued per pass, the end of a
// pass is taken from core_ready, and each finished output tile (after its
// last k-pass) is offered to writeback over of_valid/of_ready.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   layer_start  pulse, latches cfg_* and begins a layer (IDLE only)
//   abort        synchronous abort to IDLE from any state
//   cfg_m_tiles  M tiles minus 1
//   cfg_n_tiles  N tiles minus 1
//   cfg_k_tiles  K tiles minus 1
//   core_start   one-cycle pulse launching one tile pass
//   core_ready   core idle level
//   m_idx/n_idx/k_idx  current tile indices, stable during a pass
//   acc_first    accumulator overwrite flag (k_idx == 0)
//   acc_last     final k-pass flag (k_idx == latched k tiles, while busy)
//   of_valid     output tile (m_idx, n_idx) ready to drain
//   of_ready     writeback accepts the output tile
//   busy         high in every state except IDLE
//   layer_done   one-cycle pulse after the final drain is accepted
//
// Optional feature macro: LTS_PERF_CNT_EN
//   Adds parameter PERF_W and outputs perf_busy_cyc, perf_core_cyc,
//   perf_stall_cyc (saturating, cleared on an accepted layer_start).
// ---------------------------------------------------------------------------
module layer_tile_scheduler #(
   parameter int unsigned TILE_CNT_W = 8
`ifdef LTS_PERF_CNT_EN
   ,
   parameter int unsigned PERF_W     = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  layer_start,
   input  logic                  abort,
   input  logic [TILE_CNT_W-1:0] cfg_m_tiles,
   input  logic [TILE_CNT_W-1:0] cfg_n_tiles,
   input  logic [TILE_CNT_W-1:0] cfg_k_tiles,
   output logic                  core_start,
   input  logic                  core_ready,
   output logic [TILE_CNT_W-1:0] m_idx,
   output logic [TILE_CNT_W-1:0] n_idx,
   output logic [TILE_CNT_W-1:0] k_idx,
   output logic                  acc_first,
   output logic                  acc_last,
   output logic                  of_valid,
   input  logic                  of_ready,
   output logic                  busy,
   output logic                  layer_done
`ifdef LTS_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0]     perf_busy_cyc,
   output logic [PERF_W-1:0]     perf_core_cyc,
   output logic [PERF_W-1:0]     perf_stall_cyc
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [TILE_CNT_W-1:0] cfg_m, cfg_n, cfg_k;
   logic [TILE_CNT_W-1:0] cfg_m_nxt, cfg_n_nxt, cfg_k_nxt;
   logic [TILE_CNT_W-1:0] m_nxt, n_nxt, k_nxt;
   // Set after the first WAIT cycle; core_ready is still stale in that cycle
   // because the core only drops it within one clock of core_start.
   logic                  wait_seen, wait_seen_nxt;
   logic                  start_take;

   // ------------------------------------------------------------------
   // State and index registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cfg_m     <= '0;
         cfg_n     <= '0;
         cfg_k     <= '0;
         m_idx     <= '0;
         n_idx     <= '0;
         k_idx     <= '0;
         wait_seen <= 1'b0;
      end else begin
         state     <= state_nxt;
         cfg_m     <= cfg_m_nxt;
         cfg_n     <= cfg_n_nxt;
         cfg_k     <= cfg_k_nxt;
         m_idx     <= m_nxt;
         n_idx     <= n_nxt;
         k_idx     <= k_nxt;
         wait_seen <= wait_seen_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state, index stepping and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      cfg_m_nxt     = cfg_m;
      cfg_n_nxt     = cfg_n;
      cfg_k_nxt     = cfg_k;
      m_nxt         = m_idx;
      n_nxt         = n_idx;
      k_nxt         = k_idx;
      wait_seen_nxt = wait_seen;
      start_take    = 1'b0;

      core_start    = (state == S_LAUNCH);
      of_valid      = (state == S_DRAIN);
      busy          = (state != S_IDLE);
      layer_done    = (state == S_DONE);
      acc_first     = (k_idx == '0);
      // Gated by busy so the idle/reset value is 0 even though k_idx == cfg_k there.
      acc_last      = (state != S_IDLE) && (k_idx == cfg_k);

      if (abort) begin
         state_nxt     = S_IDLE;
         m_nxt         = '0;
         n_nxt         = '0;
         k_nxt         = '0;
         wait_seen_nxt = 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (layer_start) begin
                  start_take = 1'b1;
                  cfg_m_nxt  = cfg_m_tiles;
                  cfg_n_nxt  = cfg_n_tiles;
                  cfg_k_nxt  = cfg_k_tiles;
                  m_nxt      = '0;
                  n_nxt      = '0;
                  k_nxt      = '0;
                  state_nxt  = S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               wait_seen_nxt = 1'b0;
               state_nxt     = S_WAIT;
            end
            S_WAIT: begin
               wait_seen_nxt = 1'b1;
               if (wait_seen && core_ready) begin
                  if (k_idx != cfg_k) begin
                     k_nxt     = k_idx + 1'b1;
                     state_nxt = S_LAUNCH;
                  end else begin
                     state_nxt = S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (of_ready) begin
                  k_nxt = '0;
                  if (n_idx != cfg_n) begin
                     n_nxt     = n_idx + 1'b1;
                     state_nxt = S_LAUNCH;
                  end else if (m_idx != cfg_m) begin
                     n_nxt     = '0;
                     m_nxt     = m_idx + 1'b1;
                     state_nxt = S_LAUNCH;
                  end else begin
                     // Final tile: m/n keep their last values until next start.
                     state_nxt = S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

`ifdef LTS_PERF_CNT_EN
   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      sat_inc = (v == '1) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_busy_cyc  <= '0;
         perf_core_cyc  <= '0;
         perf_stall_cyc <= '0;
      end else if (start_take) begin
         perf_busy_cyc  <= '0;
         perf_core_cyc  <= '0;
         perf_stall_cyc <= '0;
      end else begin
         if (state != S_IDLE) begin
            perf_busy_cyc <= sat_inc(perf_busy_cyc);
         end
         if (state == S_WAIT) begin
            perf_core_cyc <= sat_inc(perf_core_cyc);
         end
         if ((state == S_DRAIN) && !of_ready) begin
            perf_stall_cyc <= sat_inc(perf_stall_cyc);
         end
      end
   end
`endif

endmodule

// File: tb/tb_layer_tile_scheduler.sv
module tb_layer_tile_scheduler;
   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         layer_start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] cfg_m_tiles = '0;
   logic [W-1:0] cfg_n_tiles = '0;
   logic [W-1:0] cfg_k_tiles = '0;
   logic         core_start;
   logic         core_ready = 1'b1;
   logic [W-1:0] m_idx, n_idx, k_idx;
   logic         acc_first, acc_last, of_valid;
   logic         of_ready = 1'b1;
   logic         busy, layer_done;

   layer_tile_scheduler #(.TILE_CNT_W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .layer_start (layer_start),
      .abort       (abort),
      .cfg_m_tiles (cfg_m_tiles),
      .cfg_n_tiles (cfg_n_tiles),
      .cfg_k_tiles (cfg_k_tiles),
      .core_start  (core_start),
      .core_ready  (core_ready),
      .m_idx       (m_idx),
      .n_idx       (n_idx),
      .k_idx       (k_idx),
      .acc_first   (acc_first),
      .acc_last    (acc_last),
      .of_valid    (of_valid),
      .of_ready    (of_ready),
      .busy        (busy),
      .layer_done  (layer_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      int m;
      int n;
      int k;
      int k_last;
   } tile_t;

   tile_t  pass_q[$];
   tile_t  drain_q[$];
   int     n_start = 0;
   int     n_drain = 0;
   int     n_done  = 0;
   longint cyc = 0;
   longint last_xfer = -100;
   int     core_lat = 5;
   bit     rand_lat = 1'b0;
   bit     rand_rdy = 1'b0;

   always @(posedge clk) cyc++;

   // Core model: ready drops one clock after start, rises after a latency
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst && core_start) begin
            core_ready = 1'b0;
            repeat (rand_lat ? $urandom_range(1, 4) : core_lat) @(posedge clk);
            #1;
            core_ready = 1'b1;
         end
      end
   end

   // Monitor / scoreboard consumer, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         if (core_start) begin
            n_start++;
            if (pass_q.size() == 0) begin
               check("pass_unexpected", 1, 0);
            end else begin
               tile_t p;
               p = pass_q.pop_front();
               check("pass_m", m_idx, p.m);
               check("pass_n", n_idx, p.n);
               check("pass_k", k_idx, p.k);
               check("acc_first", acc_first, (p.k == 0));
               check("acc_last", acc_last, (p.k == p.k_last));
            end
         end
         if (of_valid && of_ready) begin
            n_drain++;
            last_xfer = cyc;
            if (drain_q.size() == 0) begin
               check("drain_unexpected", 1, 0);
            end else begin
               tile_t d;
               d = drain_q.pop_front();
               check("drain_m", m_idx, d.m);
               check("drain_n", n_idx, d.n);
               check("drain_k", k_idx, d.k);
            end
         end
         if (layer_done) begin
            n_done++;
            check("done_latency", cyc - last_xfer, 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_layer(input int m, input int n, input int k);
      for (int im = 0; im <= m; im++) begin
         for (int in = 0; in <= n; in++) begin
            for (int ik = 0; ik <= k; ik++) begin
               pass_q.push_back('{m: im, n: in, k: ik, k_last: k});
            end
            drain_q.push_back('{m: im, n: in, k: k, k_last: k});
         end
      end
   endtask

   task automatic start_layer(input int m, input int n, input int k);
      push_layer(m, n, k);
      cfg_m_tiles = W'(m);
      cfg_n_tiles = W'(n);
      cfg_k_tiles = W'(k);
      layer_start = 1'b1;
      tick();
      layer_start = 1'b0;
      // Scramble cfg after the latch; must have no effect
      cfg_m_tiles = W'($urandom_range(0, 7));
      cfg_n_tiles = W'($urandom_range(0, 7));
      cfg_k_tiles = W'($urandom_range(0, 7));
   endtask

   task automatic run_to_done(input string tag, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (rand_rdy) of_ready = 1'($urandom_range(0, 1));
         if (layer_done) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      tick();
      of_ready = 1'b1;
   endtask

   task automatic wait_starts(input string tag, input int target, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (n_start >= target) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_starts_reached"}, ok, 1);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (of_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_valid_seen"}, ok, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_core_start"}, core_start, 0);
      check({tag, "_of_valid"}, of_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_layer_done"}, layer_done, 0);
      check({tag, "_acc_first"}, acc_first, 1);
      check({tag, "_acc_last"}, acc_last, 0);
      check({tag, "_m_idx"}, m_idx, 0);
      check({tag, "_n_idx"}, n_idx, 0);
      check({tag, "_k_idx"}, k_idx, 0);
   endtask

   initial begin
      int base_s, base_d, base_done;
      logic [W-1:0] sm, sn, sk;

      // Reset
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b1;
      tick();

      // T1: all-zero cfg, fixed core latency 5
      core_lat = 5;
      base_s = n_start; base_d = n_drain; base_done = n_done;
      start_layer(0, 0, 0);
      run_to_done("t1", 200);
      check("t1_starts", n_start - base_s, 1);
      check("t1_drains", n_drain - base_d, 1);
      check("t1_dones", n_done - base_done, 1);
      check("t1_busy_after", busy, 0);

      // T2: m=1 n=2 k=3, random latency and writeback backpressure
      rand_lat = 1'b1; rand_rdy = 1'b1;
      base_s = n_start; base_d = n_drain;
      start_layer(1, 2, 3);
      run_to_done("t2", 2000);
      rand_rdy = 1'b0; rand_lat = 1'b0;
      check("t2_starts", n_start - base_s, 24);
      check("t2_drains", n_drain - base_d, 6);
      check("t2_pass_q_empty", pass_q.size(), 0);
      check("t2_drain_q_empty", drain_q.size(), 0);

      // T3: writeback stall for 10 cycles
      core_lat = 2;
      of_ready = 1'b0;
      start_layer(0, 1, 0);
      wait_valid("t3", 200);
      sm = m_idx; sn = n_idx; sk = k_idx;
      base_s = n_start;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t3_valid_held", of_valid, 1);
         check("t3_m_stable", m_idx, sm);
         check("t3_n_stable", n_idx, sn);
         check("t3_k_stable", k_idx, sk);
         check("t3_no_start", core_start, 0);
      end
      check("t3_no_new_pass", n_start - base_s, 0);
      of_ready = 1'b1;
      run_to_done("t3", 300);
      check("t3_pass_q_empty", pass_q.size(), 0);

      // T4: abort while in WAIT mid-layer
      core_lat = 5;
      base_done = n_done;
      start_layer(1, 1, 1);
      wait_starts("t4", n_start + 3, 300);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_busy", busy, 0);
      check("t4_of_valid", of_valid, 0);
      check("t4_m_idx", m_idx, 0);
      check("t4_n_idx", n_idx, 0);
      check("t4_k_idx", k_idx, 0);
      pass_q.delete();
      drain_q.delete();
      repeat (20) tick();
      check("t4_no_done", n_done - base_done, 0);
      check("t4_no_start_after", pass_q.size(), 0);
      base_s = n_start;
      start_layer(0, 0, 1);
      run_to_done("t4b", 300);
      check("t4b_starts", n_start - base_s, 2);

      // Abort together with layer_start in IDLE keeps the block idle
      cfg_m_tiles = 8'd2;
      layer_start = 1'b1; abort = 1'b1;
      tick();
      layer_start = 1'b0; abort = 1'b0;
      check("abort_start_busy0", busy, 0);
      tick();
      check("abort_start_busy1", busy, 0);

      // T5: layer_start while busy is ignored
      base_s = n_start; base_done = n_done;
      start_layer(0, 0, 1);
      wait_starts("t5", n_start + 1, 100);
      cfg_m_tiles = 8'd1; cfg_n_tiles = 8'd1; cfg_k_tiles = 8'd1;
      layer_start = 1'b1;
      tick();
      layer_start = 1'b0;
      run_to_done("t5", 300);
      repeat (10) tick();
      check("t5_starts", n_start - base_s, 2);
      check("t5_dones", n_done - base_done, 1);
      check("t5_pass_q_empty", pass_q.size(), 0);

      // T6: asynchronous reset in DRAIN
      base_done = n_done;
      of_ready = 1'b0;
      start_layer(0, 0, 0);
      wait_valid("t6", 200);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      repeat (5) tick();
      check("t6_no_done", n_done - base_done, 0);
      pass_q.delete();
      drain_q.delete();
      of_ready = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      check("t6_idle_after", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
